// File: rtl/alu_issue.sv
// Execute-stage issue: decodes opcode/funct fields into the ALU control code and operands,
// then presents them through a registered valid/ready stage with a one-entry skid buffer.
// Optional feature macro: ALU_ISSUE_ILLEGAL_EN (out_illegal reports undecodable opcodes).
module alu_issue #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7_5,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic [3:0]       out_ctrl,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_LUI  = 4'b1001;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [3:0]       ctrl;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } op_t;

    op_t  dec_op;
    op_t  main_q, main_d;
    op_t  skid_q, skid_d;
    logic main_valid_q, main_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic in_ready_q, in_ready_d;
    logic accept, consume;

    // NOTE: every combinational output gets a default before the case; a missed branch would otherwise infer a latch.
    always_comb begin
        dec_op      = '0;
        dec_op.tag  = in_tag;
        dec_op.ctrl = ALU_ADD;
        case (in_opcode)
            OPC_OP: begin
                dec_op.a    = in_rs1;
                dec_op.b    = in_rs2;
                dec_op.ctrl = (in_funct3 == 3'b000 || in_funct3 == 3'b101)
                              ? {in_funct7_5, in_funct3} : {1'b0, in_funct3};
            end
            OPC_OP_IMM: begin
                // funct7_5 only distinguishes SRAI from SRLI; ADDI has no subtract form
                dec_op.a    = in_rs1;
                dec_op.b    = in_imm;
                dec_op.ctrl = (in_funct3 == 3'b101) ? {in_funct7_5, in_funct3} : {1'b0, in_funct3};
            end
            OPC_LUI: begin
                dec_op.ctrl = ALU_LUI;
                dec_op.b    = in_imm;
            end
            OPC_AUIPC: begin
                dec_op.a = in_pc;
                dec_op.b = in_imm;
            end
            OPC_LOAD, OPC_STORE: begin
                dec_op.a = in_rs1;
                dec_op.b = in_imm;
            end
            OPC_BRANCH: begin
                dec_op.a = in_rs1;
                dec_op.b = in_rs2;
                case (in_funct3[2:1])
                    2'b10:   dec_op.ctrl = ALU_SLT;
                    2'b11:   dec_op.ctrl = ALU_SLTU;
                    default: dec_op.ctrl = ALU_SUB;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                dec_op.a = in_pc;
                dec_op.b = 32'd4;
            end
            default: begin
`ifdef ALU_ISSUE_ILLEGAL_EN
                dec_op.illegal = 1'b1;
`else
                dec_op.illegal = 1'b0;
`endif
            end
        endcase
    end

    // in_ready_q mirrors !skid_valid_q, so an accept never coincides with a full skid
    always_comb begin
        accept       = in_valid && in_ready_q;
        consume      = main_valid_q && out_ready;
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (consume) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = 1'b0;
            end
        end

        if (accept) begin
            if (!main_valid_q || consume) begin
                main_d       = dec_op;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = dec_op;
                skid_valid_d = 1'b1;
            end
        end

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end

        in_ready_d = !skid_valid_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // NOTE: skid payload has no reset; it is only ever read while skid_valid_q is set.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign out_a       = main_q.a;
    assign out_b       = main_q.b;
    assign out_ctrl    = main_q.ctrl;
    assign out_tag     = main_q.tag;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: stimulus pushes expected operations, a negedge monitor pops
// and compares on each handshake; honours ALU_ISSUE_ILLEGAL_EN for the illegal flag.
module tb_alu_issue;

`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  tag;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, in_funct7_5;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
    logic [4:0]  in_tag;
    logic        out_valid, out_ready, out_illegal;
    logic [31:0] out_a, out_b;
    logic [3:0]  out_ctrl;
    logic [4:0]  out_tag;

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb[$];
    bit   rand_done;

    always #5 clk = ~clk;

    alu_issue #(.TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_ctrl(out_ctrl), .out_tag(out_tag),
        .out_illegal(out_illegal)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                                input logic [4:0] t, input logic il);
        mk = {a, b, c, t, il};
    endfunction

    // Reference decode written from the ISA mnemonics
    function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] rs1, input logic [31:0] rs2,
                                   input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] tag);
        logic [3:0] names[8];
        exp_t e;
        names = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111};
        e = mk(32'd0, 32'd0, 4'b0000, tag, 1'b0);
        case (opc)
            7'h33: begin
                e.a = rs1; e.b = rs2; e.ctrl = names[f3];
                if (f7 && f3 == 3'd0) e.ctrl = 4'b1000;
                if (f7 && f3 == 3'd5) e.ctrl = 4'b1101;
            end
            7'h13: begin
                e.a = rs1; e.b = imm; e.ctrl = names[f3];
                if (f7 && f3 == 3'd5) e.ctrl = 4'b1101;
            end
            7'h37: begin e.b = imm; e.ctrl = 4'b1001; end
            7'h17: begin e.a = pc;  e.b = imm; end
            7'h03, 7'h23: begin e.a = rs1; e.b = imm; end
            7'h63: begin
                e.a = rs1; e.b = rs2;
                if (f3 >= 3'd6)      e.ctrl = 4'b0011;
                else if (f3 >= 3'd4) e.ctrl = 4'b0010;
                else                 e.ctrl = 4'b1000;
            end
            7'h6F, 7'h67: begin e.a = pc; e.b = 32'd4; end
            default: e.illegal = ILL_EN;
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [4:0] tag, input exp_t e);
        in_valid = 1'b1; in_opcode = opc; in_funct3 = f3; in_funct7_5 = f7;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pc = pc; in_tag = tag;
        for (int i = 0; i < 200 && !in_ready; i++) tick();
        if (!in_ready) begin
            n_total++;
            $display("FAIL accept_timeout: in_ready still %b for tag %0d, expected 1", in_ready, tag);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    logic [6:0] opcs[12] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h7F, 7'h00, 7'h33};

    task automatic send_rand(input logic [4:0] tag);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1, rs2, imm, pc;
        opc = opcs[$urandom_range(0, 11)];
        f3 = 3'($urandom); f7 = 1'($urandom);
        rs1 = $urandom; rs2 = $urandom; imm = $urandom; pc = $urandom;
        send(opc, f3, f7, rs1, rs2, imm, pc, tag, model(opc, f3, f7, rs1, rs2, imm, pc, tag));
    endtask

    // Monitor: pop on handshake, and verify outputs hold while stalled
    exp_t last_seen;
    bit   prev_stall = 1'b0;
    always @(negedge clk) begin
        exp_t cur;
        cur = {out_a, out_b, out_ctrl, out_tag, out_illegal};
        if (rst_n && out_valid && prev_stall) check("hold_stable", cur, last_seen);
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL extra_op: got %h expected none", cur);
            end else begin
                check("issue", cur, sb.pop_front());
            end
        end
        prev_stall = rst_n && out_valid && !out_ready;
        last_seen  = cur;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = '0; in_funct3 = '0; in_funct7_5 = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pc = '0; in_tag = '0;
        #12;
        check("reset_state", {out_valid, in_ready, out_a, out_b, out_ctrl, out_tag, out_illegal},
              {1'b0, 1'b1, 74'd0});
        tick();
        rst_n = 1'b1;
        tick();

        // Directed decode sweep
        out_ready = 1'b1;
        send(7'h33, 3'b000, 1'b1, 32'd10, 32'd3, 32'd99, 32'd0, 5'd1, mk(32'd10, 32'd3, 4'b1000, 5'd1, 1'b0));
        check("latency", {out_valid, out_tag}, {1'b1, 5'd1});
        send(7'h13, 3'b101, 1'b1, 32'h8000_0000, 32'd7, 32'd4, 32'd0, 5'd2, mk(32'h8000_0000, 32'd4, 4'b1101, 5'd2, 1'b0));
        send(7'h13, 3'b000, 1'b1, 32'd5, 32'd9, 32'd7, 32'd0, 5'd3, mk(32'd5, 32'd7, 4'b0000, 5'd3, 1'b0));
        send(7'h37, 3'b000, 1'b0, 32'hDEAD, 32'd1, 32'h1234_5000, 32'd8, 5'd4, mk(32'd0, 32'h1234_5000, 4'b1001, 5'd4, 1'b0));
        send(7'h17, 3'b000, 1'b0, 32'd77, 32'd1, 32'h20, 32'h100, 5'd5, mk(32'h100, 32'h20, 4'b0000, 5'd5, 1'b0));
        send(7'h6F, 3'b000, 1'b0, 32'd77, 32'd1, 32'h800, 32'h40, 5'd6, mk(32'h40, 32'd4, 4'b0000, 5'd6, 1'b0));
        send(7'h63, 3'b110, 1'b0, 32'd1, 32'd2, 32'd16, 32'd0, 5'd7, mk(32'd1, 32'd2, 4'b0011, 5'd7, 1'b0));
        send(7'h7F, 3'b010, 1'b1, 32'd55, 32'd66, 32'd88, 32'h300, 5'd8, mk(32'd0, 32'd0, 4'b0000, 5'd8, ILL_EN));
        tick(); tick();

        // Backpressure: tags 1..4 with out_ready low for three edges after tag 1 issues
        out_ready = 1'b0;
        send_rand(5'd1);
        send_rand(5'd2);
        check("skid_full_in_ready", {in_ready, out_valid, out_tag}, {1'b0, 1'b1, 5'd1});
        tick(); tick();
        check("stall_in_ready", {in_ready, out_tag}, {1'b0, 5'd1});
        out_ready = 1'b1;
        tick();
        check("in_ready_reraise", {in_ready, out_valid, out_tag}, {1'b1, 1'b1, 5'd2});
        send_rand(5'd3);
        send_rand(5'd4);
        tick(); tick();
        check("bp_drained", sb.size(), 0);

        // Flush with main and skid full and a same-cycle offer
        out_ready = 1'b0;
        send_rand(5'd9);
        send_rand(5'd10);
        in_valid = 1'b1; in_opcode = 7'h33; in_tag = 5'd11; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        check("flush", {out_valid, in_ready}, {1'b0, 1'b1});
        out_ready = 1'b1;
        tick(); tick();
        check("flush_quiet", out_valid, 1'b0);

        // Asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        send_rand(5'd12);
        send_rand(5'd13);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {out_valid, in_ready, out_a, out_b, out_ctrl, out_tag, out_illegal},
              {1'b0, 1'b1, 74'd0});
        sb.delete();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        send_rand(5'd14);
        check("post_reset_latency", {out_valid, out_tag}, {1'b1, 5'd14});

        // Randomised traffic with random backpressure
        rand_done = 1'b0;
        fork
            begin
                while (!rand_done) begin
                    tick();
                    out_ready = ($urandom_range(0, 9) < 7);
                end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    int gap;
                    gap = $urandom_range(0, 3);
                    if (gap == 3) tick();
                    send_rand(5'(i));
                end
                rand_done = 1'b1;
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
        check("drain", sb.size(), 0);
        tick();
        check("idle_after_drain", {out_valid, in_ready}, {1'b0, 1'b1});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
